// File: rtl/mem_block_reader_if.sv
// Bundle of the block-read request/stream, downstream drain, status and debug
// signals of mem_block_reader. The master side is the reader itself; the slave
// side is the multiplier/downstream environment.
//
// Handshakes:
//   - EN_blockRead is a one-cycle request pulse. After it, the multiplier streams
//     words with VALID_memVal/memVal_data. That stream has no backpressure, so
//     every cycle with VALID_memVal=1 carries a word.
//   - out_valid/out_data/out_ready is a strict valid/ready pair. A word transfers
//     on a rising edge where out_valid && out_ready. While out_valid=1 and
//     out_ready=0, out_data does not change.
interface mem_block_reader_if #(
    parameter int DATA_W     = 16,
    parameter int BURST_LEN  = 64,
    parameter int FIFO_DEPTH = 128
);
    localparam int SUM_W = DATA_W + $clog2(BURST_LEN);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic              EN_fetch;
    logic              EN_blockRead;
    logic              VALID_memVal;
    logic [DATA_W-1:0] memVal_data;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic              burst_done;
    logic [SUM_W-1:0]  burst_sum;
    logic              err_overflow;
    logic              err_stray;
    logic [1:0]        dbg_state;
    logic [CNT_W-1:0]  dbg_count;

    modport master (
        input  EN_fetch, VALID_memVal, memVal_data, out_ready,
        output EN_blockRead, out_valid, out_data, burst_done, burst_sum,
               err_overflow, err_stray, dbg_state, dbg_count
    );

    modport slave (
        output EN_fetch, VALID_memVal, memVal_data, out_ready,
        input  EN_blockRead, out_valid, out_data, burst_done, burst_sum,
               err_overflow, err_stray, dbg_state, dbg_count
    );
endinterface

// File: rtl/mem_block_reader.sv
// Consumer end of the multiplier block-read stream. It issues one burst request
// only when the FIFO can absorb the whole burst, buffers the burst in a
// show-ahead FIFO that drains downstream, keeps a per-burst word sum, and raises
// sticky error flags for dropped or stray words.
module mem_block_reader #(
    parameter int DATA_W     = 16,
    parameter int BURST_LEN  = 64,
    parameter int FIFO_DEPTH = 128
) (
    input  logic               clk,
    input  logic               rst,
    mem_block_reader_if.master bus
);
    localparam int SUM_W  = DATA_W + $clog2(BURST_LEN);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int WCNT_W = $clog2(BURST_LEN) + 1;

    localparam logic [CNT_W-1:0]  DEPTH_C     = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  BURST_C     = CNT_W'(BURST_LEN);
    localparam logic [WCNT_W-1:0] LAST_WORD_C = WCNT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RECV = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic [SUM_W-1:0]   run_sum_q, run_sum_d;
    logic [SUM_W-1:0]   burst_sum_q, burst_sum_d;
    logic               err_overflow_q, err_overflow_d;
    logic               err_stray_q, err_stray_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [DATA_W-1:0]  mem_q [FIFO_DEPTH];

    logic               push_req;
    logic               do_push;
    logic               pop;
    logic               fifo_full;
    logic               head_valid;
    logic [CNT_W-1:0]   free_slots;

    assign head_valid = (count_q != '0);
    assign fifo_full  = (count_q == DEPTH_C);
    assign free_slots = DEPTH_C - count_q;
    assign pop        = head_valid && bus.out_ready;

    // Burst FSM: request gating, word counting, running sum and error detection.
    always_comb begin
        state_d        = state_q;
        wcnt_d         = wcnt_q;
        run_sum_d      = run_sum_q;
        burst_sum_d    = burst_sum_q;
        err_stray_d    = err_stray_q;
        push_req       = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Only ask for a burst the FIFO is guaranteed to hold in full.
                if (bus.EN_fetch && (free_slots >= BURST_C)) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                wcnt_d    = '0;
                run_sum_d = '0;
                state_d   = S_RECV;
            end
            S_RECV: begin
                // No timeout: gaps in the stream simply wait here.
                if (bus.VALID_memVal) begin
                    push_req  = 1'b1;
                    run_sum_d = run_sum_q + SUM_W'(bus.memVal_data);
                    wcnt_d    = wcnt_q + WCNT_W'(1);
                    if (wcnt_q == LAST_WORD_C) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                burst_sum_d = run_sum_q;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Any word outside a burst window is ignored but flagged.
        if (bus.VALID_memVal && (state_q != S_RECV)) begin
            err_stray_d = 1'b1;
        end
    end

    // FIFO bookkeeping: a pop frees the slot first, so push+pop is legal when full.
    always_comb begin
        err_overflow_d = err_overflow_q;
        do_push        = push_req && (!fifo_full || pop);
        if (push_req && fifo_full && !pop) begin
            err_overflow_d = 1'b1;
        end

        wr_ptr_d = do_push ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d = pop     ? (rd_ptr_q + AW'(1)) : rd_ptr_q;

        case ({do_push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State, counters, sums, pointers and sticky flags; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            wcnt_q         <= '0;
            run_sum_q      <= '0;
            burst_sum_q    <= '0;
            err_overflow_q <= 1'b0;
            err_stray_q    <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
        end else begin
            state_q        <= state_d;
            wcnt_q         <= wcnt_d;
            run_sum_q      <= run_sum_d;
            burst_sum_q    <= burst_sum_d;
            err_overflow_q <= err_overflow_d;
            err_stray_q    <= err_stray_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
        end
    end

    // FIFO storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem_q[wr_ptr_q] <= bus.memVal_data;
        end
    end

    assign bus.EN_blockRead = (state_q == S_REQ);
    assign bus.burst_done   = (state_q == S_DONE);
    assign bus.burst_sum    = burst_sum_q;
    assign bus.out_valid    = head_valid;
    assign bus.out_data     = head_valid ? mem_q[rd_ptr_q] : '0;
    assign bus.err_overflow = err_overflow_q;
    assign bus.err_stray    = err_stray_q;
    assign bus.dbg_state    = state_q;
    assign bus.dbg_count    = count_q;
endmodule

// File: tb/tb_mem_block_reader.sv
// Directed bench for mem_block_reader: a square-number multiplier model, a pop
// monitor feeding a received-word queue, and checks on each scenario.
module tb_mem_block_reader;
    localparam int DATA_W     = 16;
    localparam int BURST_LEN  = 64;
    localparam int FIFO_DEPTH = 128;
    localparam int SQ_SUM     = 85344;   // sum of k*k for k = 0..63

    logic clk;
    logic rst;

    mem_block_reader_if #(
        .DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .FIFO_DEPTH(FIFO_DEPTH)
    ) bus ();

    mem_block_reader #(
        .DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int passes;
    int req_cnt;
    int done_cnt;
    int stall_cnt;
    logic [DATA_W-1:0] got_q[$];

    logic              prev_v;
    logic              prev_r;
    logic              prev_rst;
    logic [DATA_W-1:0] prev_d;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Wait (bounded) for a request pulse; returns at the negedge inside REQ.
    task automatic wait_req(input string tag, input int budget);
        bit found;
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.EN_blockRead === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        check(tag, 32'(found), 32'd1);
    endtask

    // Multiplier model: stream squares first..last back to back.
    task automatic send_squares(input int first, input int last, input bit toggle);
        for (int i = first; i <= last; i++) begin
            bus.VALID_memVal = 1'b1;
            bus.memVal_data  = DATA_W'(i * i);
            if (toggle) bus.out_ready = ~bus.out_ready;
            step();
        end
        bus.VALID_memVal = 1'b0;
        bus.memVal_data  = '0;
    endtask

    task automatic wait_got(input string tag, input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (got_q.size() >= n) break;
        end
        check(tag, 32'(got_q.size()), 32'(n));
    endtask

    task automatic check_squares(input string tag, input int n);
        for (int k = 0; k < n && k < got_q.size(); k++) begin
            check($sformatf("%s[%0d]", tag, k), 32'(got_q[k]), 32'((k % 64) * (k % 64)));
        end
    endtask

    task automatic clear_monitor();
        got_q.delete();
        req_cnt  = 0;
        done_cnt = 0;
    endtask

    // Monitor: pops, pulses and stall stability of the output port.
    initial begin
        prev_v = 1'b0; prev_r = 1'b0; prev_rst = 1'b1; prev_d = '0;
    end
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.EN_blockRead === 1'b1) req_cnt++;
            if (bus.burst_done === 1'b1) done_cnt++;
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) got_q.push_back(bus.out_data);
        end
        if (prev_v && !prev_r && !prev_rst && !rst) begin
            stall_cnt++;
            checks++;
            assert (bus.out_valid === 1'b1 && bus.out_data === prev_d) passes++;
            else $error("FAIL stall_hold: observed v=%0b d=0x%0h expected v=1 d=0x%0h",
                        bus.out_valid, bus.out_data, prev_d);
        end
        prev_v   = bus.out_valid;
        prev_r   = bus.out_ready;
        prev_rst = rst;
        prev_d   = bus.out_data;
    end

    initial begin
        checks = 0; passes = 0; stall_cnt = 0;
        req_cnt = 0; done_cnt = 0;
        rst = 1'b1;
        bus.EN_fetch     = 1'b0;
        bus.VALID_memVal = 1'b0;
        bus.memVal_data  = '0;
        bus.out_ready    = 1'b0;
        repeat (3) step();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_en_blockread", 32'(bus.EN_blockRead), 32'd0);
        check("rst_out_valid",    32'(bus.out_valid),    32'd0);
        check("rst_out_data",     32'(bus.out_data),     32'd0);
        check("rst_burst_done",   32'(bus.burst_done),   32'd0);
        check("rst_burst_sum",    32'(bus.burst_sum),    32'd0);
        check("rst_err_overflow", 32'(bus.err_overflow), 32'd0);
        check("rst_err_stray",    32'(bus.err_stray),    32'd0);
        check("rst_state",        32'(bus.dbg_state),    32'd0);

        // 1: single burst of squares, drained immediately
        step();
        clear_monitor();
        bus.EN_fetch  = 1'b1;
        bus.out_ready = 1'b1;
        wait_req("t1_req", 20);
        step();
        bus.EN_fetch = 1'b0;               // dropping during RECV must not abort
        send_squares(0, 0, 1'b0);
        @(negedge clk);
        check("t1_first_visible_valid", 32'(bus.out_valid), 32'd1);
        check("t1_first_visible_data",  32'(bus.out_data),  32'd0);
        step();
        send_squares(1, 63, 1'b0);
        @(negedge clk);
        check("t1_done_pulse",      32'(bus.burst_done), 32'd1);
        check("t1_sum_before_done", 32'(bus.burst_sum),  32'd0);
        step();
        @(negedge clk);
        check("t1_done_cleared", 32'(bus.burst_done), 32'd0);
        check("t1_burst_sum",    32'(bus.burst_sum),  32'(SQ_SUM));
        wait_got("t1_words", 64, 100);
        repeat (10) step();
        check("t1_req_count",  32'(req_cnt),  32'd1);
        check("t1_done_count", 32'(done_cnt), 32'd1);
        check_squares("t1_word", 64);

        // 2: no drain -> exactly two bursts fill the FIFO, drain releases a third
        clear_monitor();
        bus.out_ready = 1'b0;
        bus.EN_fetch  = 1'b1;
        wait_req("t2_req1", 20);
        step();
        send_squares(0, 63, 1'b0);
        wait_req("t2_req2", 20);
        step();
        send_squares(0, 63, 1'b0);
        repeat (20) step();
        @(negedge clk);
        check("t2_req_count_full", 32'(req_cnt),       32'd2);
        check("t2_count_full",     32'(bus.dbg_count), 32'd128);
        check("t2_head_data",      32'(bus.out_data),  32'd0);
        check("t2_idle_full",      32'(bus.dbg_state), 32'd0);
        step();
        bus.out_ready = 1'b1;
        wait_req("t2_req3", 300);
        check("t2_room_at_req3", 32'(bus.dbg_count <= 8'd64), 32'd1);
        step();
        bus.EN_fetch = 1'b0;
        send_squares(0, 63, 1'b0);
        wait_got("t2_words", 192, 300);
        check("t2_req_count", 32'(req_cnt), 32'd3);
        check_squares("t2_word", 192);

        // 3: out_ready toggling during RECV
        repeat (5) step();
        clear_monitor();
        stall_cnt     = 0;
        bus.out_ready = 1'b1;
        bus.EN_fetch  = 1'b1;
        wait_req("t3_req", 20);
        step();
        bus.EN_fetch = 1'b0;
        send_squares(0, 63, 1'b1);
        bus.out_ready = 1'b1;
        wait_got("t3_words", 64, 200);
        check("t3_stalls_seen",   32'(stall_cnt > 0),    32'd1);
        check("t3_err_overflow",  32'(bus.err_overflow), 32'd0);
        check("t3_err_stray",     32'(bus.err_stray),    32'd0);
        check("t3_burst_sum",     32'(bus.burst_sum),    32'(SQ_SUM));
        check_squares("t3_word", 64);

        // 6: push and pop together at the fullest reachable point
        repeat (5) step();
        clear_monitor();
        bus.out_ready = 1'b0;
        bus.EN_fetch  = 1'b1;
        wait_req("t6_req1", 20);
        step();
        send_squares(0, 63, 1'b0);
        wait_req("t6_req2", 20);
        step();
        bus.EN_fetch = 1'b0;
        send_squares(0, 62, 1'b0);
        bus.VALID_memVal = 1'b1;
        bus.memVal_data  = DATA_W'(63 * 63);
        bus.out_ready    = 1'b1;
        step();
        bus.VALID_memVal = 1'b0;
        bus.out_ready    = 1'b0;
        @(negedge clk);
        check("t6_count_held",   32'(bus.dbg_count),    32'd127);
        check("t6_err_overflow", 32'(bus.err_overflow), 32'd0);
        check("t6_done_pulse",   32'(bus.burst_done),   32'd1);
        check("t6_next_head",    32'(bus.out_data),     32'd1);
        step();
        bus.out_ready = 1'b1;
        wait_got("t6_words", 128, 300);
        check_squares("t6_word", 128);

        // 4: stray word in IDLE
        repeat (3) step();
        bus.VALID_memVal = 1'b1;
        bus.memVal_data  = 16'hBEEF;
        step();
        bus.VALID_memVal = 1'b0;
        bus.memVal_data  = '0;
        @(negedge clk);
        check("t4_err_stray",    32'(bus.err_stray),    32'd1);
        check("t4_out_valid",    32'(bus.out_valid),    32'd0);
        check("t4_count",        32'(bus.dbg_count),    32'd0);
        check("t4_burst_sum",    32'(bus.burst_sum),    32'(SQ_SUM));
        check("t4_err_overflow", 32'(bus.err_overflow), 32'd0);
        check("t4_state",        32'(bus.dbg_state),    32'd0);

        // 5: reset after the 20th word; the rest of the burst is stray
        step();
        bus.EN_fetch  = 1'b1;
        bus.out_ready = 1'b1;
        wait_req("t5_req", 20);
        step();
        send_squares(0, 19, 1'b0);
        rst              = 1'b1;
        bus.EN_fetch     = 1'b0;
        bus.VALID_memVal = 1'b1;
        bus.memVal_data  = DATA_W'(20 * 20);
        step();
        rst              = 1'b0;
        bus.VALID_memVal = 1'b0;
        @(negedge clk);
        check("t5_en_blockread", 32'(bus.EN_blockRead), 32'd0);
        check("t5_out_valid",    32'(bus.out_valid),    32'd0);
        check("t5_out_data",     32'(bus.out_data),     32'd0);
        check("t5_burst_done",   32'(bus.burst_done),   32'd0);
        check("t5_burst_sum",    32'(bus.burst_sum),    32'd0);
        check("t5_err_overflow", 32'(bus.err_overflow), 32'd0);
        check("t5_err_stray",    32'(bus.err_stray),    32'd0);
        check("t5_count",        32'(bus.dbg_count),    32'd0);
        check("t5_state",        32'(bus.dbg_state),    32'd0);
        step();
        got_q.delete();
        send_squares(21, 63, 1'b0);
        repeat (3) step();
        @(negedge clk);
        check("t5_stray_after",  32'(bus.err_stray),    32'd1);
        check("t5_valid_after",  32'(bus.out_valid),    32'd0);
        check("t5_no_pops",      32'(got_q.size()),     32'd0);
        check("t5_no_request",   32'(bus.dbg_state),    32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
